// File: rtl/ftdi_rx_frame_decoder_pkg.sv
// Shared encodings for the FTDI receive-side frame decoder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ftdi_rx_frame_decoder_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_CHK     = 2'b01,
    ERR_LEN     = 2'b10,
    ERR_TIMEOUT = 2'b11
  } err_code_t;

  typedef enum logic [2:0] {
    ST_HUNT   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_LEN    = 3'd2,
    ST_DATA   = 3'd3,
    ST_CHK    = 3'd4,
    ST_COMMIT = 3'd5,
    ST_OK     = 3'd6,
    ST_ERR    = 3'd7
  } state_t;

endpackage

// File: rtl/ftdi_rx_frame_decoder_if.sv
// Bundles the engine read-FIFO handshake and the register-write/status side.
// Latency: n/a (wires only).
// Backpressure: consumer pops with ftdi_rd_fifo_en; producer holds byte while full.
interface ftdi_rx_frame_decoder_if;
  import ftdi_rx_frame_decoder_pkg::*;

  logic       ftdi_rd_fifo_full;
  logic [7:0] ftdi_rd_fifo_data;
  logic       ftdi_rd_fifo_en;
  logic       reg_wr_en;
  logic [7:0] reg_wr_addr;
  logic [7:0] reg_wr_data;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;

  // Engine / environment side
  modport master (
    output ftdi_rd_fifo_full, ftdi_rd_fifo_data,
    input  ftdi_rd_fifo_en, reg_wr_en, reg_wr_addr, reg_wr_data,
    input  frame_ok, frame_err, err_code
  );

  // Decoder side
  modport slave (
    input  ftdi_rd_fifo_full, ftdi_rd_fifo_data,
    output ftdi_rd_fifo_en, reg_wr_en, reg_wr_addr, reg_wr_data,
    output frame_ok, frame_err, err_code
  );
endinterface

// File: rtl/ftdi_rx_payload_buf.sv
// Payload staging register file: one write port, one combinational read port.
// Latency: write visible on the read port the cycle after i_wr_en.
// Backpressure: none; always accepts writes.
module ftdi_rx_payload_buf
  import ftdi_rx_frame_decoder_pkg::*;
#(
  parameter int MAX_LEN = 16,
  parameter int IDXW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic            clk_i,
  input  logic            i_wr_en,
  input  logic [IDXW-1:0] i_wr_idx,
  input  logic [7:0]      i_wr_dat,
  input  logic [IDXW-1:0] i_rd_idx,
  output logic [7:0]      o_rd_dat
);

  logic [7:0] r_mem [MAX_LEN];

  // Storage needs no reset: a slot is only read after this frame wrote it.
  always_ff @(posedge clk_i) begin
    if (i_wr_en) r_mem[i_wr_idx] <= i_wr_dat;
  end

  assign o_rd_dat = r_mem[i_rd_idx];

endmodule

// File: rtl/ftdi_rx_frame_decoder.sv
// Parses SYNC/ADDR/LEN/DATA/CHK frames from the FTDI read FIFO and commits payload as register writes.
// Latency: first reg_wr_en 1 cycle after the CHK pop, then one write per cycle; frame_ok 1 cycle after the last write.
// Backpressure: pops at most one byte every 2 cycles; no pops while committing or reporting status.
module ftdi_rx_frame_decoder
  import ftdi_rx_frame_decoder_pkg::*;
#(
  parameter int         MAX_LEN     = 16,
  parameter int         TIMEOUT_CYC = 100000,
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF
) (
  input  logic                    clk_i,
  input  logic                    async_rst,
  ftdi_rx_frame_decoder_if.slave  bus
);

  localparam int             IDXW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int             TOW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0]     MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TOW-1:0] TO_LAST   = TOW'(TIMEOUT_CYC - 1);

  state_t         r_state;
  logic           r_pop_q;
  logic [7:0]     r_addr;
  logic [7:0]     r_len;
  logic [7:0]     r_chk;
  logic [7:0]     r_idx;
  logic [TOW-1:0] r_to_cnt;
  logic           r_wr_en;
  logic [7:0]     r_wr_addr;
  logic [7:0]     r_wr_data;
  logic           r_frame_ok;
  logic           r_frame_err;
  err_code_t      r_err_code;

  logic           w_rx_state;
  logic           w_pop;
  logic           w_timeout;
  logic           w_buf_we;
  logic [7:0]     w_byte;
  logic [7:0]     w_rd_dat;

  assign w_rx_state = r_state inside {ST_HUNT, ST_ADDR, ST_LEN, ST_DATA, ST_CHK};
  // The engine drops full one cycle late, so never pop on the cycle after a pop.
  // Reset gates the pop so it is 0 as soon as reset asserts.
  assign w_pop      = w_rx_state && bus.ftdi_rd_fifo_full && !r_pop_q && !async_rst;
  assign w_timeout  = w_rx_state && (r_state != ST_HUNT) && (r_to_cnt == TO_LAST);
  assign w_byte     = bus.ftdi_rd_fifo_data;
  assign w_buf_we   = (r_state == ST_DATA) && w_pop;

  ftdi_rx_payload_buf #(
    .MAX_LEN (MAX_LEN),
    .IDXW    (IDXW)
  ) u_buf (
    .clk_i    (clk_i),
    .i_wr_en  (w_buf_we),
    .i_wr_idx (r_idx[IDXW-1:0]),
    .i_wr_dat (w_byte),
    .i_rd_idx (r_idx[IDXW-1:0]),
    .o_rd_dat (w_rd_dat)
  );

  // Remember last cycle's pop to enforce the one-pop-per-two-cycles spacing.
  always_ff @(posedge clk_i or posedge async_rst) begin
    if (async_rst) r_pop_q <= 1'b0;
    else           r_pop_q <= w_pop;
  end

  // Inter-byte idle counter: restarts on every pop, only runs inside a frame.
  always_ff @(posedge clk_i or posedge async_rst) begin
    if (async_rst)                                   r_to_cnt <= '0;
    else if (w_pop || !w_rx_state || r_state == ST_HUNT) r_to_cnt <= '0;
    else                                             r_to_cnt <= r_to_cnt + TOW'(1);
  end

  // Frame FSM with registered write strobe and status pulses.
  always_ff @(posedge clk_i or posedge async_rst) begin
    if (async_rst) begin
      r_state     <= ST_HUNT;
      r_addr      <= '0;
      r_len       <= '0;
      r_chk       <= '0;
      r_idx       <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_frame_ok  <= 1'b0;
      r_frame_err <= 1'b0;
      r_err_code  <= ERR_NONE;
    end else begin
      r_wr_en     <= 1'b0;
      r_frame_ok  <= 1'b0;
      r_frame_err <= 1'b0;
      if (w_timeout && !w_pop) begin
        r_frame_err <= 1'b1;
        r_err_code  <= ERR_TIMEOUT;
        r_state     <= ST_ERR;
      end else begin
        case (r_state)
          ST_HUNT: begin
            if (w_pop && w_byte == SYNC_BYTE) r_state <= ST_ADDR;
          end
          ST_ADDR: begin
            if (w_pop) begin
              r_addr  <= w_byte;
              r_chk   <= w_byte;
              r_state <= ST_LEN;
            end
          end
          ST_LEN: begin
            if (w_pop) begin
              r_len <= w_byte;
              r_chk <= r_chk ^ w_byte;
              r_idx <= '0;
              if (w_byte > MAX_LEN_B) begin
                r_frame_err <= 1'b1;
                r_err_code  <= ERR_LEN;
                r_state     <= ST_ERR;
              end else if (w_byte == 8'd0) begin
                r_state <= ST_CHK;
              end else begin
                r_state <= ST_DATA;
              end
            end
          end
          ST_DATA: begin
            if (w_pop) begin
              r_chk <= r_chk ^ w_byte;
              if (r_idx == r_len - 8'd1) begin
                r_idx   <= '0;
                r_state <= ST_CHK;
              end else begin
                r_idx <= r_idx + 8'd1;
              end
            end
          end
          ST_CHK: begin
            if (w_pop) begin
              if (w_byte != r_chk) begin
                r_frame_err <= 1'b1;
                r_err_code  <= ERR_CHK;
                r_state     <= ST_ERR;
              end else if (r_len == 8'd0) begin
                r_frame_ok <= 1'b1;
                r_state    <= ST_HUNT;
              end else begin
                // Issue byte 0 straight away so the first write lands 1 cycle after CHK.
                r_wr_en   <= 1'b1;
                r_wr_addr <= r_addr;
                r_wr_data <= w_rd_dat;
                r_idx     <= 8'd1;
                r_state   <= (r_len == 8'd1) ? ST_OK : ST_COMMIT;
              end
            end
          end
          ST_COMMIT: begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_addr + r_idx;
            r_wr_data <= w_rd_dat;
            if (r_idx == r_len - 8'd1) r_state <= ST_OK;
            else                       r_idx   <= r_idx + 8'd1;
          end
          ST_OK: begin
            r_frame_ok <= 1'b1;
            r_state    <= ST_HUNT;
          end
          ST_ERR: begin
            r_state <= ST_HUNT;
          end
          default: r_state <= ST_HUNT;
        endcase
      end
    end
  end

  assign bus.ftdi_rd_fifo_en = w_pop;
  assign bus.reg_wr_en       = r_wr_en;
  assign bus.reg_wr_addr     = r_wr_addr;
  assign bus.reg_wr_data     = r_wr_data;
  assign bus.frame_ok        = r_frame_ok;
  assign bus.frame_err       = r_frame_err;
  assign bus.err_code        = r_err_code;

endmodule
